// File: rtl/uart_reg_host.sv
// Register-bus initiator that configures a UART, pushes TX bytes and pops RX bytes.
// Optional access timeout with sticky bus_err is enabled by defining UART_HOST_TIMEOUT_EN.
module uart_reg_host #(
  parameter logic [3:0]  ADDR_CTRL    = 4'h0,
  parameter logic [3:0]  ADDR_BAUD_LO = 4'h2,
  parameter logic [3:0]  ADDR_BAUD_HI = 4'h3,
  parameter logic [3:0]  ADDR_STAT    = 4'h4,
  parameter logic [3:0]  ADDR_TXD     = 4'h5,
  parameter logic [3:0]  ADDR_RXD     = 4'h6,
  parameter int unsigned TXFULL_BIT   = 0,
  parameter int unsigned RXEMPTY_BIT  = 1
) (
  input  logic        app_clk,
  input  logic        srst,
  input  logic        cfg_init_req,
  input  logic [7:0]  cfg_ctrl,
  input  logic [11:0] cfg_baud,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [3:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_be,
  input  logic [7:0]  reg_rdata,
  input  logic        reg_ack,
  output logic        init_done,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE, INIT_CTRL, INIT_BLO, INIT_BHI, POLL_STAT, WR_TX, RD_RX
  } state_e;

  state_e      state_q, state_d;
  state_e      launch_st;
  logic        launch;
  logic        init_go;
  logic        done_q, done_d;
  logic        reg_cs_q, reg_cs_d;
  logic        reg_wr_q, reg_wr_d;
  logic [3:0]  reg_addr_q, reg_addr_d;
  logic [7:0]  reg_wdata_q, reg_wdata_d;
  logic        reg_be_q, reg_be_d;
  logic        tx_ready_q, tx_ready_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        init_done_q, init_done_d;
  logic        init_pend_q, init_pend_d;
  logic        stat_rxe_q, stat_rxe_d;
  logic        stat_txf_q, stat_txf_d;
`ifdef UART_HOST_TIMEOUT_EN
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;
  logic        bus_err_q, bus_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    reg_cs_d    = reg_cs_q;
    reg_wr_d    = reg_wr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_be_d    = reg_be_q;
    tx_ready_d  = 1'b0;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    init_done_d = init_done_q;
    init_pend_d = init_pend_q | cfg_init_req;
    stat_rxe_d  = stat_rxe_q;
    stat_txf_d  = stat_txf_q;
    launch      = 1'b0;
    launch_st   = IDLE;
    init_go     = init_pend_q | cfg_init_req;
`ifdef UART_HOST_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    bus_err_d   = bus_err_q & ~cfg_init_req;
`endif

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    // Each access ends with a "done" cycle (cs low) in which the next access is chosen;
    // this gives the mandatory idle cycle between accesses without extra states.
    if (state_q == IDLE) begin
      if (init_go) begin
        launch    = 1'b1;
        launch_st = INIT_CTRL;
      end else if (init_done_q && (tx_valid || !rx_valid_q)) begin
        launch    = 1'b1;
        launch_st = POLL_STAT;
      end
    end else if (done_q) begin
      done_d  = 1'b0;
      state_d = IDLE;
      if (init_go) begin
        launch    = 1'b1;
        launch_st = INIT_CTRL;
      end else begin
        case (state_q)
          INIT_CTRL: begin
            launch    = 1'b1;
            launch_st = INIT_BLO;
          end
          INIT_BLO: begin
            launch    = 1'b1;
            launch_st = INIT_BHI;
          end
          POLL_STAT: begin
            if (!stat_rxe_q && !rx_valid_q) begin
              launch    = 1'b1;
              launch_st = RD_RX;
            end else if (tx_valid && !stat_txf_q) begin
              launch    = 1'b1;
              launch_st = WR_TX;
            end
          end
          default: ;
        endcase
      end
    end else if (reg_cs_q && reg_ack) begin
      reg_cs_d = 1'b0;
      done_d   = 1'b1;
`ifdef UART_HOST_TIMEOUT_EN
      tmo_cnt_d = '0;
`endif
      case (state_q)
        INIT_BHI:  init_done_d = 1'b1;
        POLL_STAT: begin
          stat_rxe_d = reg_rdata[RXEMPTY_BIT];
          stat_txf_d = reg_rdata[TXFULL_BIT];
        end
        WR_TX:     tx_ready_d = 1'b1;
        RD_RX: begin
          rx_data_d  = reg_rdata;
          rx_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
`ifdef UART_HOST_TIMEOUT_EN
    else if (tmo_cnt_q == 8'd254) begin
      reg_cs_d  = 1'b0;
      bus_err_d = 1'b1;
      state_d   = IDLE;
      done_d    = 1'b0;
      tmo_cnt_d = '0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end
`endif

    if (launch) begin
      state_d     = launch_st;
      done_d      = 1'b0;
      reg_cs_d    = 1'b1;
      reg_be_d    = 1'b1;
      reg_wr_d    = 1'b1;
      reg_wdata_d = '0;
`ifdef UART_HOST_TIMEOUT_EN
      tmo_cnt_d   = '0;
`endif
      case (launch_st)
        INIT_CTRL: begin
          reg_addr_d  = ADDR_CTRL;
          reg_wdata_d = cfg_ctrl;
          init_done_d = 1'b0;
          init_pend_d = 1'b0;
        end
        INIT_BLO: begin
          reg_addr_d  = ADDR_BAUD_LO;
          reg_wdata_d = cfg_baud[7:0];
        end
        INIT_BHI: begin
          reg_addr_d  = ADDR_BAUD_HI;
          reg_wdata_d = {4'h0, cfg_baud[11:8]};
        end
        POLL_STAT: begin
          reg_addr_d = ADDR_STAT;
          reg_wr_d   = 1'b0;
        end
        WR_TX: begin
          reg_addr_d  = ADDR_TXD;
          reg_wdata_d = tx_data;
        end
        RD_RX: begin
          reg_addr_d = ADDR_RXD;
          reg_wr_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge app_clk) begin
    if (srst) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      reg_cs_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_be_q    <= 1'b0;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      init_done_q <= 1'b0;
      init_pend_q <= 1'b0;
      stat_rxe_q  <= 1'b1;
      stat_txf_q  <= 1'b1;
`ifdef UART_HOST_TIMEOUT_EN
      tmo_cnt_q   <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      reg_cs_q    <= reg_cs_d;
      reg_wr_q    <= reg_wr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_be_q    <= reg_be_d;
      tx_ready_q  <= tx_ready_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      init_done_q <= init_done_d;
      init_pend_q <= init_pend_d;
      stat_rxe_q  <= stat_rxe_d;
      stat_txf_q  <= stat_txf_d;
`ifdef UART_HOST_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign reg_cs    = reg_cs_q;
  assign reg_wr    = reg_wr_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_be    = reg_be_q;
  assign tx_ready  = tx_ready_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign init_done = init_done_q;
`ifdef UART_HOST_TIMEOUT_EN
  assign bus_err   = bus_err_q;
`else
  assign bus_err   = 1'b0;
`endif

endmodule

// File: doc/uart_reg_host.md
UART_REG_HOST -- requirements
Module: uart_reg_host

Interface
REQ-001 Parameters SHALL be as follows (name, default, meaning):
- ADDR_CTRL, 4'h0, control register address.
- ADDR_BAUD_LO, 4'h2, baud[7:0] address.
- ADDR_BAUD_HI, 4'h3, baud[11:8] address.
- ADDR_STAT, 4'h4, status register address.
- ADDR_TXD, 4'h5, TX data address.
- ADDR_RXD, 4'h6, RX data address.
- TXFULL_BIT, 0, status bit: TX FIFO full.
- RXEMPTY_BIT, 1, status bit: RX FIFO empty.

REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- app_clk, in, 1, the single clock.
- srst, in, 1, reset; synchronous, active-high.
- cfg_init_req, in, 1, one-cycle pulse that starts the init sequence.
- cfg_ctrl, in, 8, control byte written at init.
- cfg_baud, in, 12, baud divisor written at init.
- tx_valid, in, 1, TX byte offered.
- tx_data, in, 8, TX byte.
- tx_ready, out, 1, TX byte consumed.
- rx_valid, out, 1, RX byte held.
- rx_data, out, 8, RX byte.
- rx_ready, in, 1, RX byte taken.
- reg_cs, out, 1, access strobe.
- reg_wr, out, 1, 1 = write, 0 = read.
- reg_addr, out, 4, register address.
- reg_wdata, out, 8, write data.
- reg_be, out, 1, byte enable.
- reg_rdata, in, 8, read data.
- reg_ack, in, 1, access complete.
- init_done, out, 1, init sequence finished.
- bus_err, out, 1, sticky access timeout.

Function
REQ-003 Block SHALL act as reg-bus initiator; it owns UART configuration, TX push and RX pop.
REQ-004 FSM states SHALL be IDLE, INIT_CTRL, INIT_BLO, INIT_BHI, POLL_STAT, WR_TX, RD_RX.
REQ-005 Each non-IDLE state SHALL be one access:
- reg_cs, reg_wr, reg_addr, reg_wdata and reg_be (=1) are registered and rise on the edge entering the state.
- They stay stable until the edge on which reg_ack=1 is sampled.
- reg_cs falls on that edge.
REQ-006 reg_cs SHALL be low for at least one cycle between accesses; minimum access length is 2 cycles.
REQ-007 Init sequence SHALL run INIT_CTRL (write cfg_ctrl) -> INIT_BLO (write cfg_baud[7:0]) -> INIT_BHI (write {4'h0,cfg_baud[11:8]}) -> IDLE.
- init_done clears when INIT_CTRL is entered.
- init_done sets on the ack of INIT_BHI.
- cfg_ctrl and cfg_baud are sampled at access launch.
REQ-008 cfg_init_req during an access SHALL be latched as pending; init starts after that access completes and has priority over all other work.
REQ-009 From IDLE with init_done=1: if tx_valid=1 or rx_valid=0, the FSM SHALL enter POLL_STAT (read ADDR_STAT); otherwise it stays in IDLE.
REQ-010 On POLL_STAT ack, the next state SHALL be decided by the following priority (RX first, so the RX FIFO does not overflow):
- If rdata[RXEMPTY_BIT]=0 and rx_valid=0: go to RD_RX.
- Else if tx_valid=1 and rdata[TXFULL_BIT]=0: go to WR_TX.
- Else: go to IDLE.
REQ-011 WR_TX SHALL write tx_data to ADDR_TXD.
- tx_data is captured at launch.
- tx_ready is a one-cycle pulse on the ack edge.
- tx_valid and tx_data must stay stable until tx_ready.
REQ-012 RD_RX SHALL read ADDR_RXD.
- On the ack edge: rx_data <= reg_rdata and rx_valid <= 1.
- rx_valid stays high until the cycle rx_valid=1 and rx_ready=1 is sampled, then clears on that edge.
REQ-013 Only one access SHALL be outstanding at a time.
REQ-014 When a status poll finds no work, the block SHALL re-poll after returning to IDLE (at least one idle cycle).
REQ-015 reg_ack sampled while reg_cs=0 SHALL be ignored.

Reset
REQ-016 While srst=1 at a clock edge, the following SHALL hold after that edge:
- state = IDLE.
- reg_cs, reg_wr, reg_be, reg_addr, reg_wdata = 0.
- tx_ready, rx_valid, init_done, bus_err = 0.
- rx_data = 8'h00.
- Pending init cleared; timeout counter = 0.
REQ-017 srst asserted mid-access SHALL abandon the access immediately: reg_cs=0 next cycle, no tx_ready, no rx load.

Configuration
REQ-018 Macro UART_HOST_TIMEOUT_EN, when defined, SHALL add an 8-bit counter of cycles with reg_cs=1 and no ack. On reaching 255 the block SHALL:
- drop reg_cs;
- set bus_err;
- return to IDLE without tx_ready and without an rx load;
- abort an init in progress, leaving init_done=0.
REQ-019 bus_err SHALL clear only on srst or cfg_init_req.
REQ-020 Without UART_HOST_TIMEOUT_EN, accesses SHALL wait indefinitely and bus_err SHALL be tied 0.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Init: cfg_init_req with cfg_ctrl=8'h03, cfg_baud=12'h0A0, ack 1 cycle after cs -> writes (0,03), (2,A0), (3,00) in order; init_done=1 after the third ack.
- TX path: tx_valid with tx_data=8'h55, status=8'h02 -> read addr 4, write (5,55), tx_ready pulses once; status=8'h03 -> no write, re-poll.
- RX path: status=8'h00, rdata=8'hA7, rx_ready=0 -> rx_valid=1, rx_data=A7, no further RD_RX until rx_ready=1; simultaneous tx_valid is served after the RX pop.
- Init during access: cfg_init_req during WR_TX -> WR_TX completes with tx_ready, then INIT_CTRL starts next.
- srst mid-RD_RX: reg_cs=0 next cycle, rx_valid=0, state IDLE.
- With UART_HOST_TIMEOUT_EN, ack withheld: reg_cs drops after 255 cycles and bus_err=1; cfg_init_req clears bus_err.
